// File: rtl/pong_motion_ctrl.sv
// rtl/pong_motion_ctrl.sv - frame-rate ball/paddle motion and serve/miss/game-over sequencing
module pong_motion_ctrl #(
  parameter int PADDLE_X    = 600,
  parameter int BALL_V      = 2,
  parameter int PADDLE_V    = 4,
  parameter int LIVES_INIT  = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  input  logic       serve,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_x,
  output logic [9:0] paddle_y,
  output logic       hit,
  output logic       miss,
  output logic [1:0] lives,
  output logic       game_over
);

  // Screen geometry shared with the renderer
  localparam logic [9:0] WALL      = 10'd16;
  localparam logic [9:0] BALL_SIZE = 10'd16;
  localparam logic [9:0] PADDLE_H  = 10'd64;
  localparam logic [9:0] Y_BOTTOM  = 10'd464;
  localparam logic [9:0] X_RIGHT   = 10'd640;
  localparam logic [9:0] PY_MIN    = 10'd16;
  localparam logic [9:0] PY_MAX    = 10'd400;

  // Serve / reset positions
  localparam logic [9:0] BALL_X0   = 10'd320;
  localparam logic [9:0] BALL_Y0   = 10'd232;
  localparam logic [9:0] PADDLE_Y0 = 10'd208;

  localparam logic [9:0] PX     = 10'(PADDLE_X);
  localparam logic [9:0] PV     = 10'(PADDLE_V);
  localparam logic [9:0] BV_POS = 10'(BALL_V);
  localparam logic [9:0] BV_NEG = 10'(-BALL_V);
  localparam logic [1:0] LIVES0 = 2'(LIVES_INIT);

  localparam int CW = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [CW-1:0] MISS_LAST = CW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_MISS      = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t        state;
  logic [9:0]    dx;
  logic [9:0]    dy;
  logic [CW-1:0] miss_cnt;

  logic [9:0] paddle_next;
  logic [9:0] dx_next;
  logic [9:0] dy_next;
  logic       hit_next;
  logic       miss_now;
  logic       paddle_contact;
  logic [9:0] ball_right;
  logic [9:0] ball_bottom;

  assign paddle_x    = PX;
  assign ball_right  = ball_x + BALL_SIZE;
  assign ball_bottom = ball_y + BALL_SIZE;

  // Paddle target for this tick from the buttons, clamped to the playfield
  always_comb begin
    paddle_next = paddle_y;
    if (btn == 2'b10) begin
      paddle_next = (paddle_y >= PY_MIN + PV) ? paddle_y - PV : PY_MIN;
    end else if (btn == 2'b01) begin
      paddle_next = (paddle_y + PV <= PY_MAX) ? paddle_y + PV : PY_MAX;
    end
  end

  // Bounce decisions from the current ball position (paddle position before this tick's move)
  always_comb begin
    miss_now       = (ball_right >= X_RIGHT);
    paddle_contact = !dx[9] && (dx != 10'd0) &&
                     (ball_right >= PX) && (ball_right <= PX + 10'd15) &&
                     (ball_bottom > paddle_y) && (ball_y < paddle_y + PADDLE_H);
    dy_next = dy;
    if (ball_y <= WALL) begin
      dy_next = BV_POS;
    end else if (ball_bottom >= Y_BOTTOM) begin
      dy_next = BV_NEG;
    end
    dx_next  = dx;
    hit_next = 1'b0;
    if (ball_x <= WALL) begin
      dx_next = BV_POS;
    end else if (paddle_contact) begin
      dx_next  = BV_NEG;
      hit_next = 1'b1;
    end
  end

  // Game state machine with registered positions and pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx        <= BV_POS;
      dy        <= BV_POS;
      paddle_y  <= PADDLE_Y0;
      lives     <= LIVES0;
      miss_cnt  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (refr_tick && (state == S_IDLE || state == S_PLAY)) begin
        paddle_y <= paddle_next;
      end
      case (state)
        S_IDLE: begin
          if (serve) begin
            state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (refr_tick) begin
            if (miss_now) begin
              state    <= S_MISS;
              miss     <= 1'b1;
              miss_cnt <= '0;
              if (lives != 2'd0) begin
                lives <= lives - 2'd1;
              end
            end else begin
              dx     <= dx_next;
              dy     <= dy_next;
              ball_x <= ball_x + dx_next;
              ball_y <= ball_y + dy_next;
              hit    <= hit_next;
            end
          end
        end
        S_MISS: begin
          if (refr_tick) begin
            if (miss_cnt == MISS_LAST) begin
              if (lives == 2'd0) begin
                state     <= S_GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state  <= S_IDLE;
                ball_x <= BALL_X0;
                ball_y <= BALL_Y0;
                dx     <= BV_POS;
                dy     <= BV_POS;
              end
            end else begin
              miss_cnt <= miss_cnt + CW'(1);
            end
          end
        end
        S_GAME_OVER: begin
          if (serve) begin
            state     <= S_IDLE;
            game_over <= 1'b0;
            lives     <= LIVES0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            dx        <= BV_POS;
            dy        <= BV_POS;
            paddle_y  <= PADDLE_Y0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// tb/tb_pong_motion_ctrl.sv - self-checking bench for pong_motion_ctrl against a game-rule model
module tb_pong_motion_ctrl;
  localparam int PADDLE_X    = 600;
  localparam int BALL_V      = 2;
  localparam int PADDLE_V    = 4;
  localparam int LIVES_INIT  = 3;
  localparam int MISS_FRAMES = 60;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refr_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       serve = 1'b0;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle_x;
  logic [9:0] paddle_y;
  logic       hit;
  logic       miss;
  logic [1:0] lives;
  logic       game_over;

  pong_motion_ctrl #(
    .PADDLE_X(PADDLE_X), .BALL_V(BALL_V), .PADDLE_V(PADDLE_V),
    .LIVES_INIT(LIVES_INIT), .MISS_FRAMES(MISS_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .refr_tick(refr_tick), .btn(btn), .serve(serve),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x), .paddle_y(paddle_y),
    .hit(hit), .miss(miss), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain integers, signed velocities
  int m_mode, m_bx, m_by, m_vx, m_vy, m_py, m_lives, m_pause;
  int m_hit, m_miss, m_over;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic serve_position();
    m_bx = 320; m_by = 232; m_vx = BALL_V; m_vy = BALL_V;
  endtask

  task automatic model_reset();
    serve_position();
    m_py = 208; m_lives = LIVES_INIT; m_mode = M_IDLE; m_pause = 0;
    m_hit = 0; m_miss = 0; m_over = 0;
  endtask

  task automatic model_step(input bit rst, input bit tk, input bit [1:0] b, input bit sv);
    int old_py, nvx, nvy;
    bit contact;
    m_hit = 0; m_miss = 0;
    if (rst) begin
      model_reset();
      return;
    end
    old_py = m_py;
    if (tk && (m_mode == M_IDLE || m_mode == M_PLAY)) begin
      if (b == 2'b10) m_py = (m_py - PADDLE_V < 16) ? 16 : m_py - PADDLE_V;
      else if (b == 2'b01) m_py = (m_py + PADDLE_V > 400) ? 400 : m_py + PADDLE_V;
    end
    case (m_mode)
      M_IDLE: if (sv) m_mode = M_PLAY;
      M_PLAY: if (tk) begin
        if (m_bx + 16 >= 640) begin
          m_mode = M_PAUSE; m_pause = MISS_FRAMES; m_miss = 1;
          if (m_lives > 0) m_lives--;
        end else begin
          nvx = m_vx; nvy = m_vy;
          if (m_by <= 16) nvy = BALL_V;
          else if (m_by + 16 >= 464) nvy = -BALL_V;
          contact = (m_vx > 0) && (m_bx + 16 >= PADDLE_X) && (m_bx + 16 <= PADDLE_X + 15)
                    && (m_by + 16 > old_py) && (m_by < old_py + 64);
          if (m_bx <= 16) nvx = BALL_V;
          else if (contact) begin nvx = -BALL_V; m_hit = 1; end
          m_vx = nvx; m_vy = nvy;
          m_bx = (m_bx + nvx) & 1023;
          m_by = (m_by + nvy) & 1023;
        end
      end
      M_PAUSE: if (tk) begin
        m_pause--;
        if (m_pause == 0) begin
          if (m_lives == 0) m_mode = M_OVER;
          else begin serve_position(); m_mode = M_IDLE; end
        end
      end
      default: if (sv) begin
        m_lives = LIVES_INIT; serve_position(); m_py = 208; m_mode = M_IDLE;
      end
    endcase
    m_over = (m_mode == M_OVER) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("ball_x", ball_x, m_bx);
    check("ball_y", ball_y, m_by);
    check("paddle_x", paddle_x, PADDLE_X);
    check("paddle_y", paddle_y, m_py);
    check("hit", hit, m_hit);
    check("miss", miss, m_miss);
    check("lives", lives, m_lives);
    check("game_over", game_over, m_over);
  endtask

  task automatic cycle(input bit rst, input bit tk, input bit [1:0] b, input bit sv);
    @(negedge clk);
    reset = rst; refr_tick = tk; btn = b; serve = sv;
    model_step(rst, tk, b, sv);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ball_x"}, ball_x, 320);
    check({tag, "_ball_y"}, ball_y, 232);
    check({tag, "_paddle_x"}, paddle_x, 600);
    check({tag, "_paddle_y"}, paddle_y, 208);
    check({tag, "_lives"}, lives, 3);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_miss"}, miss, 0);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  // Ticks with no buttons until a miss pulse; returns the tick index or -1
  task automatic run_to_miss(output int at);
    at = -1;
    for (int t = 1; t <= 300; t++) begin
      cycle(0, 1, 2'b00, 0);
      if (miss === 1'b1) begin at = t; break; end
    end
    if (at < 0) check("miss_timeout", 0, 1);
  endtask

  initial begin
    int first_at, miss_at;
    bit rst, tk, sv;
    bit [1:0] b;
    model_reset();

    // Reset state and IDLE hold
    cycle(1, 0, 2'b00, 0);
    cycle(1, 0, 2'b00, 0);
    check_reset_values("reset");
    for (int i = 0; i < 10; i++) cycle(0, 1, 2'b00, 0);
    check("idle_ball_x", ball_x, 320);
    check("idle_ball_y", ball_y, 232);

    // Serve, first move, paddle up to the top wall
    cycle(0, 0, 2'b00, 1);
    cycle(0, 1, 2'b10, 0);
    check("first_move_x", ball_x, 322);
    check("first_move_y", ball_y, 234);
    first_at = (paddle_y == 10'd16) ? 1 : -1;
    for (int i = 2; i <= 60; i++) begin
      cycle(0, 1, 2'b10, 0);
      if (paddle_y == 10'd16 && first_at < 0) first_at = i;
    end
    check("paddle_top_tick", first_at, 48);
    check("paddle_top_hold", paddle_y, 16);

    // Bottom bounce, miss, pause, back to IDLE
    cycle(1, 0, 2'b00, 0);
    cycle(0, 0, 2'b00, 1);
    miss_at = -1;
    for (int t = 1; t <= 200; t++) begin
      cycle(0, 1, 2'b00, 0);
      if (t == 108) check("y_at_108", ball_y, 448);
      if (t == 109) check("y_at_109", ball_y, 446);
      if (t == 152) check("x_at_152", ball_x, 624);
      if (miss === 1'b1) begin miss_at = t; break; end
    end
    check("miss_tick", miss_at, 153);
    check("miss_lives", lives, 2);
    cycle(0, 0, 2'b00, 0);
    check("miss_pulse_width", miss, 0);
    for (int k = 1; k <= 60; k++) begin
      cycle(0, 1, 2'b00, 0);
      if (k == 59) check("frozen_x", ball_x, 624);
    end
    check("reserve_x", ball_x, 320);
    check("reserve_y", ball_y, 232);
    cycle(0, 1, 2'b00, 0);
    check("idle_after_miss_x", ball_x, 320);

    // Paddle hit with down held
    cycle(1, 0, 2'b00, 0);
    cycle(0, 0, 2'b01, 1);
    for (int t = 1; t <= 136; t++) begin
      cycle(0, 1, 2'b01, 0);
      if (t == 48) check("paddle_bottom", paddle_y, 400);
      if (t == 132) begin
        check("pre_hit_x", ball_x, 584);
        check("pre_hit_y", ball_y, 400);
        check("pre_hit_pulse", hit, 0);
      end
      if (t == 133) begin
        check("hit_pulse", hit, 1);
        check("hit_x", ball_x, 582);
        cycle(0, 0, 2'b01, 0);
        check("hit_pulse_width", hit, 0);
      end
      if (t == 134) check("after_hit_x", ball_x, 580);
    end

    // Three misses to game over, then restart
    cycle(1, 0, 2'b00, 0);
    for (int m = 1; m <= 3; m++) begin
      cycle(0, 0, 2'b00, 1);
      run_to_miss(miss_at);
      check("lives_after_miss", lives, 3 - m);
      for (int k = 1; k <= 60; k++) cycle(0, 1, 2'b00, 0);
      check("game_over_flag", game_over, (m == 3) ? 1 : 0);
    end
    for (int k = 0; k < 5; k++) cycle(0, 1, 2'b01, 0);
    check("over_frozen_paddle", paddle_y, 208);
    cycle(0, 0, 2'b00, 1);
    check("restart_lives", lives, 3);
    check("restart_game_over", game_over, 0);
    cycle(0, 1, 2'b00, 0);
    check("restart_idle_x", ball_x, 320);

    // Reset coinciding with a tick mid-play
    cycle(0, 0, 2'b00, 1);
    for (int t = 0; t < 20; t++) cycle(0, 1, 2'b01, 0);
    cycle(1, 1, 2'b01, 1);
    check_reset_values("midplay_reset");

    // Randomized play against the model
    b = 2'b00;
    for (int i = 0; i < 20000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      tk  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) b = 2'($urandom);
      sv  = ($urandom_range(0, 29) == 0);
      cycle(rst, tk, b, sv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pong_motion_ctrl.md
Name: pong_motion_ctrl

Overview:
Frame-rate game-state engine that produces the ball and paddle positions consumed by the pong pixel renderer. On each frame-refresh tick it moves the paddle from the buttons and moves the ball. It bounces the ball off the walls and the paddle, detects misses, and sequences serve, play, miss-pause and game-over. All positions are top-left corners in the 640x480 screen space and use the renderer's geometry: walls 16 px, paddle 16x64, ball 16x16.

Parameters:
PADDLE_X, 600, fixed paddle left edge
BALL_V, 2, ball speed per tick on each axis (px)
PADDLE_V, 4, paddle speed per tick (px)
LIVES_INIT, 3, lives at reset and on restart
MISS_FRAMES, 60, ticks frozen after a miss

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
refr_tick  in  1  one-clk pulse per frame; all motion happens only on this pulse
btn  in  2  btn[1]=up, btn[0]=down (level)
serve  in  1  level; start play / restart after game over
ball_x  out  10  ball left edge
ball_y  out  10  ball top edge
paddle_x  out  10  paddle left edge (constant PADDLE_X)
paddle_y  out  10  paddle top edge
hit  out  1  one-clk pulse on paddle hit
miss  out  1  one-clk pulse on miss
lives  out  2  remaining lives
game_over  out  1  high while in GAME_OVER

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - ball = (320, 232); paddle_y = 208; paddle_x = PADDLE_X.
  - dx = +BALL_V, dy = +BALL_V.
  - lives = LIVES_INIT; hit = 0, miss = 0, game_over = 0.
  - state = IDLE.
- Reset overrides every other input in the same cycle.
- States: IDLE, PLAY, MISS, GAME_OVER.
- IDLE:
  - Ball is held at (320, 232), with dx and dy at the serve values.
  - serve=1 moves to PLAY on the next clk edge.
  - If refr_tick coincides with that edge, the ball does not move on it.
- Paddle, in IDLE and PLAY, on refr_tick only:
  - up only: paddle_y = paddle_y-PADDLE_V if paddle_y >= 16+PADDLE_V, else 16.
  - down only: paddle_y = paddle_y+PADDLE_V if paddle_y+PADDLE_V <= 400, else 400.
  - Both or neither pressed: paddle holds.
  - Paddle is frozen in MISS and GAME_OVER.
- Ball in PLAY, on refr_tick:
  - Compute new dx and dy from the current position, then ball += new velocity.
  - Arithmetic is in 10-bit unsigned; dx and dy are signed and added two's-complement.
  - dy rule: ball_y <= 16 gives dy = +BALL_V; else ball_y+16 >= 464 gives dy = -BALL_V.
  - dx, left wall: ball_x <= 16 gives dx = +BALL_V.
  - dx, paddle hit: dx > 0, ball_x+16 in [PADDLE_X, PADDLE_X+15], ball_y+16 > paddle_y and ball_y < paddle_y+64. Result: dx = -BALL_V and hit pulses.
  - Miss: ball_x+16 >= 640 enters MISS. The ball is not moved on that tick, and the miss condition takes priority over the y bounce.
  - A paddle hit and a y bounce on the same tick both apply.
- hit and miss are registered: high for exactly the single clk following the deciding tick edge.
- MISS:
  - On entry: lives decrements (saturating at 0) and miss pulses.
  - Ball stays frozen for MISS_FRAMES ticks.
  - Then: lives == 0 goes to GAME_OVER; otherwise the ball and velocity reload the serve values and the state goes to IDLE.
- GAME_OVER:
  - game_over = 1; the ball stays frozen.
  - serve=1 reloads lives = LIVES_INIT, the ball and velocity reload, paddle_y = 208, and the state goes to IDLE.
- No movement of any kind occurs on cycles without refr_tick.

Test Plan:
- Reset -> ball (320,232), paddle (600,208), lives=3, hit=miss=game_over=0; IDLE with 10 ticks -> ball unchanged.
- serve, then 1 tick -> ball (322,234); hold up for 60 ticks -> paddle_y reaches 16 after 48 ticks, then stays 16.
- Serve, no buttons -> at tick 108 ball_y=448; tick 109 -> dy flips, ball_y=446; at x=624 -> miss pulse for 1 clk, lives=2; ball frozen 60 ticks; then IDLE with ball (320,232).
- Hold down throughout, serve -> paddle_y=400 by tick 48; ball reaches (584,400) at tick 132; tick 133 -> hit pulse for 1 clk, ball_x=582, dx negative.
- Three consecutive misses -> lives 2,1,0 -> game_over=1 after the third pause; serve -> lives=3, IDLE, game_over=0.
- Assert reset mid-PLAY coincident with refr_tick -> every output returns to its reset value on that edge.
